ats_cmd_capture: RTL and testbench

Parametrised multi-client command capture front end for the ATS alarm/timer system. After a single `req` strobe, it collects one multi-word instruction from every client control bus. It assembles each instruction MSB-word first, discards NOP and reserved opcodes, and queues the rest in a shared FIFO tagged with the client index. The block sits between the client control buses and the ATS clock/alarm/timer core, which drains commands through a valid/ready interface.

---
 rtl/ats_pkg.sv | 33 +++
 rtl/ats_cmd_fifo.sv | 55 +++++
 rtl/ats_cmd_capture.sv | 151 +++++++++++++++
 tb/tb_ats_cmd_capture.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ats_pkg.sv
// Shared types for the ATS command capture front end: opcodes, status codes and FSM states.
package ats_pkg;

  typedef enum logic [2:0] {
    OP_NOP       = 3'b000,
    OP_SET_CLK   = 3'b001,
    OP_EN_CLK    = 3'b010,
    OP_SET_MODE  = 3'b011,
    OP_RSVD      = 3'b100,
    OP_SET_ALARM = 3'b101,
    OP_SET_TIMER = 3'b110,
    OP_EN_AT     = 3'b111
  } ats_op_e;

  typedef enum logic [1:0] {
    STAT_OK         = 2'b00,
    STAT_BUSY       = 2'b01,
    STAT_ERR_OPCODE = 2'b10,
    STAT_REJECT     = 2'b11
  } ats_stat_e;

  typedef enum logic [1:0] {
    CAP_IDLE    = 2'b00,
    CAP_CAPTURE = 2'b01,
    CAP_COMMIT  = 2'b10
  } cap_state_e;

  // NOP and the reserved opcode never reach the core.
  function automatic logic op_is_queued(input logic [2:0] op);
    return !(op == OP_NOP || op == OP_RSVD);
  endfunction

endpackage

// File: rtl/ats_cmd_fifo.sv
// Shared command queue: DEPTH entries, head visible combinationally, push and pop may coincide
// at any occupancy (including full, where the popped slot is reused in the same edge).
module ats_cmd_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic [CNT_W-1:0] count,
  output logic [CNT_W-1:0] free
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign do_pop    = pop && (count != '0);
  assign do_push   = push && ((count != CNT_W'(DEPTH)) || do_pop);
  assign head_data = mem[rd_ptr];
  assign free      = CNT_W'(DEPTH) - count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/ats_cmd_capture.sv
// Multi-client command capture: one req collects a WORDS-word instruction from every client,
// filters NOP/reserved opcodes and queues the rest, tagged with the client index.
module ats_cmd_capture
  import ats_pkg::*;
#(
  parameter int NUM_CLIENTS = 2,
  parameter int WORD_W      = 16,
  parameter int WORDS       = 2,
  parameter int DEPTH       = 4,
  localparam int CMD_W      = WORDS * WORD_W,
  localparam int CID_W      = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               req,
  input  logic [NUM_CLIENTS-1:0][WORD_W-1:0] ctrl,
  output logic                               ready,
  output logic [1:0]                         stat,
  output logic                               cmd_valid,
  input  logic                               cmd_ready,
  output logic [CMD_W-1:0]                   cmd_data,
  output logic [CID_W-1:0]                   cmd_client,
  output logic [2:0]                         cmd_op
);

  localparam int IDX_W  = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int CNT_W  = $clog2(DEPTH + 1);
  localparam int FIFO_W = CID_W + CMD_W;

  cap_state_e       state_q, state_d;
  logic [IDX_W-1:0] idx_q;
  logic [IDX_W-1:0] slot;
  logic [CID_W-1:0] cli_q;
  ats_stat_e        stat_q;
  logic             err_q;
  logic             init_q;
  logic [CMD_W-1:0] asm_q [NUM_CLIENTS];
  logic [2:0]       commit_op;

  logic             accept;
  logic             rejected;
  logic             last_word;
  logic             last_client;
  logic             push;
  logic             rsvd_hit;

  logic [FIFO_W-1:0] head;
  logic [CNT_W-1:0]  fifo_count;
  logic [CNT_W-1:0]  fifo_free;

  // init_q keeps ready low until the first edge after reset release.
  assign ready     = init_q && (state_q == CAP_IDLE) && (fifo_free >= CNT_W'(NUM_CLIENTS));
  assign slot      = IDX_W'(WORDS - 1) - idx_q;
  assign commit_op = asm_q[cli_q][CMD_W-1 -: 3];
  assign rsvd_hit  = (state_q == CAP_COMMIT) && (commit_op == OP_RSVD);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= CAP_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    accept      = 1'b0;
    rejected    = 1'b0;
    last_word   = 1'b0;
    last_client = 1'b0;
    push        = 1'b0;
    case (state_q)
      CAP_IDLE: begin
        if (req) begin
          if (ready) begin
            accept  = 1'b1;
            state_d = CAP_CAPTURE;
          end else begin
            rejected = 1'b1;
          end
        end
      end
      CAP_CAPTURE: begin
        if (idx_q == IDX_W'(WORDS - 1)) begin
          last_word = 1'b1;
          state_d   = CAP_COMMIT;
        end
      end
      CAP_COMMIT: begin
        push = op_is_queued(commit_op);
        if (cli_q == CID_W'(NUM_CLIENTS - 1)) begin
          last_client = 1'b1;
          state_d     = CAP_IDLE;
        end
      end
      default: state_d = CAP_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      init_q <= 1'b0;
      idx_q  <= '0;
      cli_q  <= '0;
      err_q  <= 1'b0;
      stat_q <= STAT_OK;
    end else begin
      init_q <= 1'b1;
      if (accept)                      idx_q <= '0;
      else if (state_q == CAP_CAPTURE) idx_q <= last_word ? '0 : idx_q + 1'b1;

      if (last_word)                  cli_q <= '0;
      else if (state_q == CAP_COMMIT) cli_q <= last_client ? '0 : cli_q + 1'b1;

      if (accept)        err_q <= 1'b0;
      else if (rsvd_hit) err_q <= 1'b1;

      // REJECT is only overwritten by the next accepted request.
      if (accept)           stat_q <= STAT_BUSY;
      else if (rejected)    stat_q <= STAT_REJECT;
      else if (last_client) stat_q <= (err_q || rsvd_hit) ? STAT_ERR_OPCODE : STAT_OK;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_CLIENTS; i++) asm_q[i] <= '0;
    end else if (state_q == CAP_CAPTURE) begin
      for (int i = 0; i < NUM_CLIENTS; i++)
        asm_q[i][int'(slot)*WORD_W +: WORD_W] <= ctrl[i];
    end
  end

  ats_cmd_fifo #(
    .WIDTH (FIFO_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (reset),
    .push      (push),
    .push_data ({cli_q, asm_q[cli_q]}),
    .pop       (cmd_ready),
    .head_data (head),
    .count     (fifo_count),
    .free      (fifo_free)
  );

  assign stat       = stat_q;
  assign cmd_valid  = (fifo_count != '0);
  assign cmd_data   = cmd_valid ? head[CMD_W-1:0] : '0;
  assign cmd_client = cmd_valid ? head[FIFO_W-1 -: CID_W] : '0;
  assign cmd_op     = cmd_data[CMD_W-1 -: 3];

endmodule

// File: tb/tb_ats_cmd_capture.sv
// Directed bench for ats_cmd_capture with default parameters (2 clients, 2x16-bit words, depth 4).
module tb_ats_cmd_capture;

  logic             clk = 1'b0;
  logic             reset;
  logic             req;
  logic [1:0][15:0] ctrl;
  logic             ready;
  logic [1:0]       stat;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [31:0]      cmd_data;
  logic [0:0]       cmd_client;
  logic [2:0]       cmd_op;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [0:0]  cid;
    logic [31:0] data;
    logic [2:0]  op;
  } pop_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  push;
    logic [1:0]  stat;
  } vec_t;

  pop_t popq[$];
  pop_t expq[$];
  vec_t vecs[7];

  ats_cmd_capture dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .ctrl       (ctrl),
    .ready      (ready),
    .stat       (stat),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_data   (cmd_data),
    .cmd_client (cmd_client),
    .cmd_op     (cmd_op)
  );

  always #5 clk = ~clk;

  // A handshake seen at the falling edge is the pop taken on the next rising edge.
  always @(negedge clk) begin
    if (!reset && cmd_valid && cmd_ready) begin
      pop_t p;
      p.cid  = cmd_client;
      p.data = cmd_data;
      p.op   = cmd_op;
      popq.push_back(p);
    end
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic expect_push(input logic [0:0] cid, input logic [31:0] d);
    pop_t p;
    p.cid  = cid;
    p.data = d;
    p.op   = d[31:29];
    expq.push_back(p);
  endtask

  task automatic check_pops(input string name);
    check($sformatf("%s_count", name), popq.size(), expq.size());
    for (int i = 0; i < expq.size() && i < popq.size(); i++) begin
      check($sformatf("%s[%0d]_cid", name, i),  32'(popq[i].cid),  32'(expq[i].cid));
      check($sformatf("%s[%0d]_data", name, i), popq[i].data,      expq[i].data);
      check($sformatf("%s[%0d]_op", name, i),   32'(popq[i].op),   32'(expq[i].op));
    end
    popq.delete();
    expq.delete();
  endtask

  // Called and returns at posedge+1.
  task automatic wait_ready();
    int n = 0;
    while (!ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("ready_wait", 32'(ready), 32'd1);
  endtask

  task automatic do_txn(input logic [31:0] a, input logic [31:0] b);
    wait_ready();
    req = 1'b1;
    @(posedge clk); #1;              // E0
    req  = 1'b0;
    ctrl = {b[31:16], a[31:16]};
    @(negedge clk);
    check("stat_busy", 32'(stat), 32'd1);
    @(posedge clk); #1;              // E1: MSB word
    ctrl = {b[15:0], a[15:0]};
    @(posedge clk); #1;              // E2: LSB word
    ctrl = '0;
    @(posedge clk);                  // E3: client 0 commit
    @(posedge clk); #1;              // E4: client 1 commit
  endtask

  initial begin
    vecs[0] = '{32'h2000_0000, 32'h2240_0000, 2'b11, 2'b00};
    vecs[1] = '{32'h0000_0000, 32'h4280_0000, 2'b10, 2'b00};
    vecs[2] = '{32'h8000_1234, 32'h2000_0000, 2'b10, 2'b10};
    vecs[3] = '{32'hC000_0001, 32'hE000_FFFF, 2'b11, 2'b00};
    vecs[4] = '{32'h0000_5555, 32'h8000_0000, 2'b00, 2'b10};
    vecs[5] = '{32'hA5A5_0F0F, 32'h0000_0001, 2'b01, 2'b00};
    vecs[6] = '{32'h7FFF_FFFF, 32'h9000_0000, 2'b01, 2'b10};

    reset     = 1'b1;
    req       = 1'b0;
    ctrl      = '0;
    cmd_ready = 1'b1;
    @(negedge clk);
    check("rst_ready",      32'(ready),      32'd0);
    check("rst_stat",       32'(stat),       32'd0);
    check("rst_cmd_valid",  32'(cmd_valid),  32'd0);
    check("rst_cmd_data",   cmd_data,        32'd0);
    check("rst_cmd_client", 32'(cmd_client), 32'd0);
    reset = 1'b0;
    #1;
    check("ready_before_first_edge", 32'(ready), 32'd0);
    @(posedge clk); #1;
    check("ready_after_first_edge", 32'(ready), 32'd1);

    for (int v = 0; v < 7; v++) begin
      do_txn(vecs[v].a, vecs[v].b);
      check($sformatf("vec%0d_stat", v), 32'(stat), 32'(vecs[v].stat));
      if (vecs[v].push[0]) expect_push(1'b0, vecs[v].a);
      if (vecs[v].push[1]) expect_push(1'b1, vecs[v].b);
      repeat (3) begin @(posedge clk); #1; end
      check_pops($sformatf("vec%0d", v));
    end

    // Backpressure fill, reject, and ready recovery one pop at a time.
    cmd_ready = 1'b0;
    do_txn(32'h2000_0000, 32'h2240_0000);
    check("bp_ready_half", 32'(ready), 32'd1);
    do_txn(32'hC000_0001, 32'hE000_FFFF);
    check("bp_ready_full", 32'(ready), 32'd0);
    check("bp_head_valid", 32'(cmd_valid), 32'd1);
    check("bp_head_data", cmd_data, 32'h2000_0000);
    req  = 1'b1;
    ctrl = {16'h2000, 16'h2000};
    @(posedge clk); #1;
    req = 1'b0;
    check("bp_stat_reject", 32'(stat), 32'd3);
    repeat (5) begin @(posedge clk); #1; end
    check("bp_ready_still_low", 32'(ready), 32'd0);
    check("bp_reject_sticky", 32'(stat), 32'd3);
    check("bp_head_stable", cmd_data, 32'h2000_0000);
    check("bp_head_op", 32'(cmd_op), 32'd1);
    ctrl = '0;
    cmd_ready = 1'b1;
    @(posedge clk); #1;
    cmd_ready = 1'b0;
    check("bp_ready_after_pop1", 32'(ready), 32'd0);
    check("bp_head_after_pop1", cmd_data, 32'h2240_0000);
    check("bp_client_after_pop1", 32'(cmd_client), 32'd1);
    cmd_ready = 1'b1;
    @(posedge clk); #1;
    cmd_ready = 1'b0;
    check("bp_ready_after_pop2", 32'(ready), 32'd1);
    check("bp_stat_after_pops", 32'(stat), 32'd3);
    cmd_ready = 1'b1;
    repeat (4) begin @(posedge clk); #1; end
    expect_push(1'b0, 32'h2000_0000);
    expect_push(1'b1, 32'h2240_0000);
    expect_push(1'b0, 32'hC000_0001);
    expect_push(1'b1, 32'hE000_FFFF);
    check_pops("bp");

    // Reset in the cycle after E1 with two entries still queued.
    cmd_ready = 1'b0;
    do_txn(32'h2000_0000, 32'h2240_0000);
    wait_ready();
    req = 1'b1;
    @(posedge clk); #1;
    req  = 1'b0;
    ctrl = {16'h4280, 16'h2000};
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    check("midrst_cmd_valid", 32'(cmd_valid), 32'd0);
    check("midrst_ready",     32'(ready),     32'd0);
    check("midrst_stat",      32'(stat),      32'd0);
    check("midrst_cmd_data",  cmd_data,       32'd0);
    reset = 1'b0;
    ctrl  = '0;
    #1;
    check("midrst_ready_pre_edge", 32'(ready), 32'd0);
    @(posedge clk); #1;
    check("midrst_ready_post_edge", 32'(ready), 32'd1);
    cmd_ready = 1'b1;
    do_txn(32'h6000_0001, 32'hE123_4567);
    check("midrst_stat_done", 32'(stat), 32'd0);
    repeat (3) begin @(posedge clk); #1; end
    expect_push(1'b0, 32'h6000_0001);
    expect_push(1'b1, 32'hE123_4567);
    check_pops("midrst");

    // Back-to-back transactions, concurrent push/pop, pointers wrap five times.
    cmd_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      logic [31:0] a;
      logic [31:0] b;
      a = {3'b001, 29'(i * 7 + 1)};
      b = {3'b110, 29'(i * 13 + 5)};
      expect_push(1'b0, a);
      expect_push(1'b1, b);
      do_txn(a, b);
    end
    repeat (3) begin @(posedge clk); #1; end
    check("wrap_stat", 32'(stat), 32'd0);
    check_pops("wrap");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
